// File: rtl/pcm_device_responder.sv
// pcm_device_responder
//   Stand-in for a parallel PCM device on the addr/data/ce_n/oe_n/we_n bus.
//   Decodes lock/unlock, buffer program (E8h AND-program, EAh overwrite),
//   read array/status and clear status commands, backed by a small word
//   array with per-block lock bits.
// Ports:
//   clk    system clock (bus inputs are asynchronous to it)
//   rst_n  asynchronous active-low reset
//   addr   word address, only addr[AW-1:0] decoded
//   data   bidirectional data, driven only during an enabled read
//   ce_n   chip enable (active low)
//   oe_n   output enable (active low)
//   we_n   write enable (active low)
//   busy   high while a program operation executes
//   sr     current status register
module pcm_device_responder #(
    parameter int AW       = 8,
    parameter int BLK_AW   = 4,
    parameter int READ_LAT = 8,
    parameter int PROG_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [22:0] addr,
    inout  wire  [15:0] data,
    input  logic        ce_n,
    input  logic        oe_n,
    input  logic        we_n,
    output logic        busy,
    output logic [7:0]  sr
);

    localparam int NBLK  = 2 ** (AW - BLK_AW);
    localparam int DEPTH = 2 ** AW;
    localparam int RCW   = $clog2(READ_LAT + 1);
    localparam int PCW   = $clog2(PROG_CYC + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOCK    = 3'd1;
    localparam logic [2:0] S_BCOUNT  = 3'd2;
    localparam logic [2:0] S_BDATA   = 3'd3;
    localparam logic [2:0] S_BCONF   = 3'd4;
    localparam logic [2:0] S_BUSY    = 3'd5;

    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[22:AW];

    // Bus pipeline: stages 1/2 synchronize, stage 3 is the previous
    // synchronized sample used for we_n edge detection and write capture.
    logic [AW-1:0] a1, a2, a3;
    logic [15:0]   d1, d2, d3;
    logic          c1, c2, c3;
    logic          o1, o2;
    logic          w1, w2, w3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1 <= '0; a2 <= '0; a3 <= '0;
            d1 <= '0; d2 <= '0; d3 <= '0;
            c1 <= 1'b1; c2 <= 1'b1; c3 <= 1'b1;
            o1 <= 1'b1; o2 <= 1'b1;
            w1 <= 1'b1; w2 <= 1'b1; w3 <= 1'b1;
        end else begin
            a1 <= addr[AW-1:0]; a2 <= a1; a3 <= a2;
            d1 <= data;         d2 <= d1; d3 <= d2;
            c1 <= ce_n;         c2 <= c1; c3 <= c2;
            o1 <= oe_n;         o2 <= o1;
            w1 <= we_n;         w2 <= w1; w3 <= w2;
        end
    end

    logic wr_evt;
    logic rd_cond;
    assign wr_evt  = w2 & ~w3 & ~c3;
    assign rd_cond = ~c2 & ~o2 & w2;

    // Control state
    logic [2:0]      state;
    logic            mode_status;
    logic            sr5, sr4, sr1;
    logic            op_ea;
    logic [4:0]      cnt_n;
    logic [4:0]      rcvd;
    logic [AW-1:0]   start;
    logic [4:0]      k;
    logic            prog_phase;
    logic [PCW-1:0]  ovh;
    logic [NBLK-1:0] locks;

    logic [15:0] mem  [DEPTH];
    logic [15:0] pbuf [32];

    assign busy = (state == S_BUSY);
    assign sr   = {~busy, 1'b0, sr5, sr4, 2'b00, sr1, 1'b0};

    // Buffer slot of the current data write, relative to the start address
    logic [AW-1:0] slot;
    logic          slot_ok;
    logic          buf_we;
    logic [4:0]    buf_idx;

    always_comb begin
        slot    = (rcvd == 5'd0) ? '0 : a3 - start;
        slot_ok = (slot <= {{(AW-5){1'b0}}, cnt_n});
        buf_idx = slot[4:0];
        buf_we  = wr_evt && (state == S_BDATA) && slot_ok;
    end

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [15:0]   mem_wdata;

    always_comb begin
        mem_we    = (state == S_BUSY) && !prog_phase;
        mem_waddr = start + {{(AW-5){1'b0}}, k};
        mem_wdata = op_ea ? pbuf[k] : (mem[mem_waddr] & pbuf[k]);
    end

    always_ff @(posedge clk) begin
        if (buf_we) pbuf[buf_idx] <= d3;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Command FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            mode_status <= 1'b0;
            sr5         <= 1'b0;
            sr4         <= 1'b0;
            sr1         <= 1'b0;
            op_ea       <= 1'b0;
            cnt_n       <= '0;
            rcvd        <= '0;
            start       <= '0;
            k           <= '0;
            prog_phase  <= 1'b0;
            ovh         <= '0;
            locks       <= '1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (wr_evt) begin
                        case (d3[7:0])
                            8'hFF: mode_status <= 1'b0;
                            8'h70: mode_status <= 1'b1;
                            8'h50: begin
                                sr5 <= 1'b0;
                                sr4 <= 1'b0;
                                sr1 <= 1'b0;
                            end
                            8'h60: state <= S_LOCK;
                            8'hE8, 8'hEA: begin
                                state       <= S_BCOUNT;
                                mode_status <= 1'b1;
                                op_ea       <= (d3[7:0] == 8'hEA);
                            end
                            default: ;
                        endcase
                    end
                end
                S_LOCK: begin
                    if (wr_evt) begin
                        if (d3[7:0] == 8'hD0) begin
                            locks[a3[AW-1:BLK_AW]] <= 1'b0;
                        end else if (d3[7:0] == 8'h01) begin
                            locks[a3[AW-1:BLK_AW]] <= 1'b1;
                        end else begin
                            sr5 <= 1'b1;
                            sr4 <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                end
                S_BCOUNT: begin
                    if (wr_evt) begin
                        if (d3[15:5] != '0) begin
                            sr5   <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            cnt_n <= d3[4:0];
                            rcvd  <= '0;
                            state <= S_BDATA;
                        end
                    end
                end
                S_BDATA: begin
                    if (wr_evt) begin
                        if (rcvd == 5'd0) start <= a3;
                        if (!slot_ok) sr4 <= 1'b1;
                        rcvd <= rcvd + 5'd1;
                        if (rcvd == cnt_n) state <= S_BCONF;
                    end
                end
                S_BCONF: begin
                    if (wr_evt) begin
                        if (d3[7:0] == 8'hD0) begin
                            state <= S_BUSY;
                            k     <= '0;
                            // A locked start block skips the word phase
                            // and only burns the fixed overhead.
                            if (locks[start[AW-1:BLK_AW]]) begin
                                sr1        <= 1'b1;
                                sr4        <= 1'b1;
                                prog_phase <= 1'b1;
                                ovh        <= PCW'(PROG_CYC - 1);
                            end else begin
                                prog_phase <= 1'b0;
                            end
                        end else begin
                            sr5   <= 1'b1;
                            sr4   <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                end
                S_BUSY: begin
                    if (wr_evt && d3[7:0] == 8'h70) mode_status <= 1'b1;
                    if (!prog_phase) begin
                        k <= k + 5'd1;
                        if (k == cnt_n) begin
                            prog_phase <= 1'b1;
                            ovh        <= PCW'(PROG_CYC - 1);
                        end
                    end else if (ovh == '0) begin
                        state <= S_IDLE;
                    end else begin
                        ovh <= ovh - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read path: output enable after READ_LAT qualified cycles, data
    // registered from the synchronized address.
    logic [RCW-1:0] rd_cnt;
    logic [15:0]    rdata;
    logic           drive;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt <= '0;
            rdata  <= '0;
        end else begin
            if (!rd_cond) begin
                rd_cnt <= '0;
            end else if (rd_cnt != RCW'(READ_LAT)) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            rdata <= (mode_status || busy) ? {8'h00, sr} : mem[a2];
        end
    end

    assign drive = rd_cond && (rd_cnt == RCW'(READ_LAT));
    assign data  = drive ? rdata : 16'hzzzz;

endmodule

// File: tb/tb_pcm_device_responder.sv
// Self-checking bench for pcm_device_responder: bus-level command tasks,
// a word-array/lock/status reference model, scenario tasks run in order.
module tb_pcm_device_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [22:0] addr;
    logic        ce_n, oe_n, we_n;
    logic [15:0] dq;
    logic        dq_en;
    wire  [15:0] data;
    logic        busy;
    logic [7:0]  sr;

    always #5 clk = ~clk;
    assign data = dq_en ? dq : 16'hzzzz;

    pcm_device_responder #(
        .AW(8), .BLK_AW(4), .READ_LAT(8), .PROG_CYC(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .data(data),
        .ce_n(ce_n), .oe_n(oe_n), .we_n(we_n), .busy(busy), .sr(sr)
    );

    // Reference model
    logic [15:0] mm [256];
    bit          lk [16];
    bit          s5, s4, s1;
    logic [15:0] wbuf [32];
    int          checks = 0;
    int          passed = 0;

    function automatic logic [15:0] model_status();
        return {8'h00, 1'b1, 1'b0, s5, s4, 2'b00, s1, 1'b0};
    endfunction

    task automatic model_prog(input bit ea, input int s, input int n, input int limit);
        if (lk[s / 16]) begin
            s1 = 1'b1;
            s4 = 1'b1;
        end else begin
            for (int j = 0; j <= n && j < limit; j++) begin
                automatic int a = (s + j) % 256;
                mm[a] = ea ? wbuf[j] : (mm[a] & wbuf[j]);
            end
        end
    endtask

    // Bus tasks
    task automatic bus_write(input int a, input logic [15:0] d);
        @(posedge clk); #1;
        addr = 23'(a); dq = d; dq_en = 1'b1;
        ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0;
        repeat (3) @(posedge clk); #1 we_n = 1'b1;
        repeat (3) @(posedge clk); #1 ce_n = 1'b1; dq_en = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic bus_read(input int a, output logic [15:0] d);
        @(posedge clk); #1;
        addr = 23'(a); ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
        repeat (13) @(posedge clk);
        @(negedge clk) d = data;
        @(posedge clk); #1 ce_n = 1'b1; oe_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic wait_idle(output bit to);
        to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic set_lock(input int a, input bit lock);
        bus_write(a, 16'h0060);
        bus_write(a, lock ? 16'h0001 : 16'h00D0);
        lk[(a % 256) / 16] = lock;
    endtask

    task automatic send_program(input bit ea, input int s, input int n, input bit confirm);
        bus_write(s, ea ? 16'h00EA : 16'h00E8);
        bus_write(s, 16'(n));
        for (int i = 0; i <= n; i++) bus_write((s + i) % 256, wbuf[i]);
        if (confirm) bus_write(s, 16'h00D0);
    endtask

    // Scenarios
    task automatic test_reset();
        logic [15:0] r;
        rst_n = 1'b0; ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
        addr = '0; dq = '0; dq_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        checks++; if (sr !== 8'h80) $display("FAIL reset_sr got=%h exp=80", sr); else passed++;
        rst_n = 1'b1;
        for (int b = 0; b < 16; b++) lk[b] = 1'b1;
        s5 = 0; s4 = 0; s1 = 0;
        repeat (3) @(posedge clk);
        bus_write(0, 16'h0070);
        bus_read(0, r);
        checks++; if (r !== 16'h0080) $display("FAIL reset_status got=%h exp=0080", r); else passed++;
        bus_write(0, 16'h00FF);
    endtask

    task automatic test_init_fill();
        bit to;
        logic [15:0] r;
        for (int b = 0; b < 16; b++) set_lock(b * 16, 1'b0);
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 32; i++) wbuf[i] = 16'($urandom);
            send_program(1'b1, p * 32, 31, 1'b1);
            wait_idle(to);
            checks++; if (to !== 1'b0) $display("FAIL fill_busy_timeout got=%b exp=0", to); else passed++;
            model_prog(1'b1, p * 32, 31, 32);
        end
        bus_read(0, r);
        checks++; if (r !== model_status()) $display("FAIL fill_status got=%h exp=%h", r, model_status()); else passed++;
        bus_write(0, 16'h00FF);
    endtask

    task automatic test_array_read();
        logic [15:0] r;
        bus_read(0, r);
        checks++; if (r !== mm[0]) $display("FAIL array_read0 got=%h exp=%h", r, mm[0]); else passed++;
        for (int i = 0; i < 8; i++) begin
            automatic int a = $urandom_range(0, 255);
            bus_read(a, r);
            checks++; if (r !== mm[a]) $display("FAIL array_read a=%0h got=%h exp=%h", a, r, mm[a]); else passed++;
        end
    endtask

    task automatic test_buffer_program();
        logic [15:0] r;
        bit to;
        set_lock(5, 1'b0);
        for (int i = 0; i < 32; i++) wbuf[i] = 16'(i);
        send_program(1'b1, 5, 31, 1'b1);
        bus_read(0, r);
        checks++; if (r[7] !== 1'b0) $display("FAIL poll_busy_sr7 got=%b exp=0", r[7]); else passed++;
        wait_idle(to);
        checks++; if (to !== 1'b0) $display("FAIL bp_busy_timeout got=%b exp=0", to); else passed++;
        model_prog(1'b1, 5, 31, 32);
        bus_read(0, r);
        checks++; if (r !== 16'h0080) $display("FAIL bp_status got=%h exp=0080", r); else passed++;
        bus_write(0, 16'h00FF);
        for (int i = 0; i < 32; i++) begin
            bus_read(5 + i, r);
            checks++; if (r !== 16'(i)) $display("FAIL bp_read a=%0h got=%h exp=%h", 5 + i, r, 16'(i)); else passed++;
        end
    endtask

    task automatic test_e8_and();
        logic [15:0] r;
        bit to;
        wbuf[0] = 16'h00F0;
        send_program(1'b1, 8'h37, 0, 1'b1); wait_idle(to); model_prog(1'b1, 8'h37, 0, 1);
        wbuf[0] = 16'h00CC;
        send_program(1'b0, 8'h37, 0, 1'b1); wait_idle(to); model_prog(1'b0, 8'h37, 0, 1);
        bus_write(0, 16'h00FF);
        bus_read(8'h37, r);
        checks++; if (r !== 16'h00C0) $display("FAIL e8_and got=%h exp=00C0", r); else passed++;
        send_program(1'b1, 8'h37, 0, 1'b1); wait_idle(to); model_prog(1'b1, 8'h37, 0, 1);
        bus_write(0, 16'h00FF);
        bus_read(8'h37, r);
        checks++; if (r !== 16'h00CC) $display("FAIL ea_overwrite got=%h exp=00CC", r); else passed++;
    endtask

    task automatic test_locked();
        logic [15:0] r;
        bit to;
        set_lock(8'h90, 1'b1);
        for (int i = 0; i < 8; i++) wbuf[i] = 16'($urandom);
        send_program(1'b1, 8'h90, 7, 1'b1);
        wait_idle(to);
        checks++; if (to !== 1'b0) $display("FAIL lk_busy_timeout got=%b exp=0", to); else passed++;
        model_prog(1'b1, 8'h90, 7, 8);
        bus_read(0, r);
        checks++; if (r !== 16'h0092) $display("FAIL locked_status got=%h exp=0092", r); else passed++;
        bus_write(0, 16'h00FF);
        for (int i = 0; i < 8; i += 3) begin
            bus_read(8'h90 + i, r);
            checks++; if (r !== mm[8'h90 + i]) $display("FAIL locked_unchanged a=%0h got=%h exp=%h", 8'h90 + i, r, mm[8'h90 + i]); else passed++;
        end
        bus_write(0, 16'h0050); s5 = 0; s4 = 0; s1 = 0;
        bus_write(0, 16'h0070);
        bus_read(0, r);
        checks++; if (r !== 16'h0080) $display("FAIL clear_status got=%h exp=0080", r); else passed++;
        bus_write(0, 16'h00FF);
    endtask

    task automatic test_seq_errors();
        logic [15:0] r;
        bit to;
        logic [15:0] keep;
        bus_write(8'h20, 16'h00EA);
        bus_write(8'h20, 16'h0020);
        s5 = 1'b1;
        bus_read(0, r);
        checks++; if (r !== 16'h00A0) $display("FAIL count_err got=%h exp=00A0", r); else passed++;
        bus_write(8'h20, 16'h00EA);
        bus_write(8'h20, 16'h0000);
        bus_write(8'h20, 16'($urandom));
        bus_write(8'h20, 16'h00FF);
        s5 = 1'b1; s4 = 1'b1;
        bus_read(0, r);
        checks++; if (r !== 16'h00B0) $display("FAIL confirm_err got=%h exp=00B0", r); else passed++;
        bus_write(0, 16'h00FF);
        bus_read(8'h20, r);
        checks++; if (r !== mm[8'h20]) $display("FAIL confirm_err_array got=%h exp=%h", r, mm[8'h20]); else passed++;
        bus_write(0, 16'h0050); s5 = 0; s4 = 0; s1 = 0;
        // Out-of-range slot: a preceding 2-word program makes slot 1 and
        // mem[61h] agree, so the unwritten slot cannot change the array.
        wbuf[0] = 16'($urandom); wbuf[1] = 16'($urandom);
        send_program(1'b1, 8'h60, 1, 1'b1); wait_idle(to); model_prog(1'b1, 8'h60, 1, 2);
        keep = wbuf[1];
        wbuf[0] = 16'($urandom);
        bus_write(8'h60, 16'h00EA);
        bus_write(8'h60, 16'h0001);
        bus_write(8'h60, wbuf[0]);
        bus_write(8'h65, 16'($urandom));
        bus_write(8'h60, 16'h00D0);
        wait_idle(to);
        wbuf[1] = keep;
        model_prog(1'b1, 8'h60, 1, 2);
        s4 = 1'b1;
        bus_read(0, r);
        checks++; if (r !== 16'h0090) $display("FAIL slot_range_status got=%h exp=0090", r); else passed++;
        bus_write(0, 16'h00FF);
        bus_read(8'h65, r);
        checks++; if (r !== mm[8'h65]) $display("FAIL slot_range_discard got=%h exp=%h", r, mm[8'h65]); else passed++;
        bus_read(8'h60, r);
        checks++; if (r !== mm[8'h60]) $display("FAIL slot_range_word0 got=%h exp=%h", r, mm[8'h60]); else passed++;
        bus_write(0, 16'h0050); s5 = 0; s4 = 0; s1 = 0;
    endtask

    task automatic test_wrap();
        logic [15:0] r;
        bit to;
        int pts [4] = '{8'hF8, 8'hFF, 8'h00, 8'h07};
        set_lock(0, 1'b1);
        set_lock(8'hF8, 1'b0);
        for (int i = 0; i < 16; i++) wbuf[i] = 16'($urandom);
        send_program(1'b1, 8'hF8, 15, 1'b1);
        wait_idle(to);
        model_prog(1'b1, 8'hF8, 15, 16);
        bus_read(0, r);
        checks++; if (r !== 16'h0080) $display("FAIL wrap_status got=%h exp=0080", r); else passed++;
        bus_write(0, 16'h00FF);
        for (int i = 0; i < 4; i++) begin
            bus_read(pts[i], r);
            checks++; if (r !== mm[pts[i]]) $display("FAIL wrap_read a=%0h got=%h exp=%h", pts[i], r, mm[pts[i]]); else passed++;
        end
        set_lock(0, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] r;
        bit to;
        for (int it = 0; it < 6; it++) begin
            automatic int  s    = $urandom_range(0, 255);
            automatic int  n    = $urandom_range(0, 31);
            automatic bit  ea   = 1'($urandom_range(0, 1));
            automatic bit  lock = ($urandom_range(0, 3) == 0);
            set_lock(s, lock);
            for (int i = 0; i < 32; i++) wbuf[i] = 16'($urandom);
            send_program(ea, s, n, 1'b1);
            wait_idle(to);
            checks++; if (to !== 1'b0) $display("FAIL rnd_busy_timeout got=%b exp=0", to); else passed++;
            model_prog(ea, s, n, 32);
            bus_read(0, r);
            checks++; if (r !== model_status()) $display("FAIL rnd_status got=%h exp=%h", r, model_status()); else passed++;
            bus_write(0, 16'h0050); s5 = 0; s4 = 0; s1 = 0;
            bus_write(0, 16'h00FF);
            for (int j = 0; j < 3; j++) begin
                automatic int a = (s + $urandom_range(0, n)) % 256;
                bus_read(a, r);
                checks++; if (r !== mm[a]) $display("FAIL rnd_read a=%0h got=%h exp=%h", a, r, mm[a]); else passed++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] r;
        bit to;
        bit seen;
        set_lock(8'h40, 1'b0);
        for (int i = 0; i < 32; i++) wbuf[i] = 16'($urandom);
        send_program(1'b1, 8'h40, 31, 1'b0);
        seen = 1'b0;
        fork
            bus_write(8'h40, 16'h00D0);
            begin
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (busy === 1'b1) begin
                        seen = 1'b1;
                        break;
                    end
                end
                if (seen) begin
                    repeat (10) @(posedge clk);
                    #1 rst_n = 1'b0;
                    #3 rst_n = 1'b1;
                end
            end
        join
        checks++; if (seen !== 1'b1) $display("FAIL midreset_busy_seen got=%b exp=1", seen); else passed++;
        model_prog(1'b1, 8'h40, 31, 10);
        for (int b = 0; b < 16; b++) lk[b] = 1'b1;
        s5 = 0; s4 = 0; s1 = 0;
        @(negedge clk);
        checks++; if (sr !== 8'h80) $display("FAIL midreset_sr got=%h exp=80", sr); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL midreset_busy got=%b exp=0", busy); else passed++;
        for (int i = 0; i < 32; i++) begin
            bus_read(8'h40 + i, r);
            checks++; if (r !== mm[8'h40 + i]) $display("FAIL midreset_read a=%0h got=%h exp=%h", 8'h40 + i, r, mm[8'h40 + i]); else passed++;
        end
        wbuf[0] = 16'($urandom);
        send_program(1'b1, 8'h40, 0, 1'b1);
        wait_idle(to);
        model_prog(1'b1, 8'h40, 0, 1);
        bus_read(0, r);
        checks++; if (r !== 16'h0092) $display("FAIL midreset_relocked got=%h exp=0092", r); else passed++;
    endtask

    initial begin
        test_reset();
        test_init_fill();
        test_array_read();
        test_buffer_program();
        test_e8_and();
        test_locked();
        test_seq_errors();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
